// File: rtl/tt_eval_pkg.sv
// tt_eval_pkg: shared FSM states and sizing helpers for the truth-table evaluator
package tt_eval_pkg;
  localparam int N_IN_MAX = 8;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/tt_lut_mux.sv
// tt_lut_mux: combinational select of one truth-table row
module tt_lut_mux #(
  parameter int N_IN = 4,
  parameter int TT_W = 16
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] sel,
  output logic            y
);
  assign y = tt[sel];
endmodule

// File: rtl/tt_sweep_eval.sv
// tt_sweep_eval: loadable truth-table evaluator with streamed and exhaustive-sweep modes; TT_SWEEP_MISMATCH_CNT_EN adds mismatch_cnt
module tt_sweep_eval
  import tt_eval_pkg::*;
#(
  parameter int           N_IN   = 4,
  parameter int           TT_W   = tt_width(N_IN),
  parameter logic [255:0] TT_RST = 256'h2FC7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [TT_W-1:0] cfg_tt,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  input  logic            sweep_start,
  input  logic [TT_W-1:0] expected_tt,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            sweep_match,
`ifdef TT_SWEEP_MISMATCH_CNT_EN
  output logic [N_IN:0]   mismatch_cnt,
`endif
  output logic [TT_W-1:0] sweep_tt
);
  state_t state, state_n;
  logic [TT_W-1:0] tt, exp_l, tt_next;
  logic [N_IN-1:0] idx, sel;
  logic lut_bit, start_acc, xfer, last;
  assign sel = state == SWEEP ? idx : in_vec;
  tt_lut_mux #(.N_IN(N_IN), .TT_W(TT_W)) u_lut (.tt(tt), .sel(sel), .y(lut_bit));
  // Handshake, sweep control and the table as it will look after this sweep row
  always_comb begin
    in_ready = !rst && state == IDLE && !sweep_start && (!out_valid || out_ready);
    xfer = in_valid && in_ready;
    start_acc = state == IDLE && sweep_start && !out_valid;
    last = state == SWEEP && &idx;
    state_n = state == DONE ? IDLE : last ? DONE : start_acc ? SWEEP : state;
    sweep_busy = state == SWEEP;
    sweep_done = state == DONE;
    tt_next = sweep_tt;
    tt_next[idx] = lut_bit;
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Truth table; frozen during a sweep so every row sees the same function
  always_ff @(posedge clk or posedge rst)
    if (rst) tt <= TT_RST[TT_W-1:0];
    else if (cfg_we && state != SWEEP) tt <= cfg_tt;
  // Stream result register with hold under backpressure
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_bit <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_bit <= lut_bit;
    end else if (out_ready) out_valid <= 1'b0;
  // Sweep row walk, table rebuild and final comparison
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      exp_l <= '0;
      sweep_tt <= '0;
      sweep_match <= 1'b0;
    end else if (start_acc) begin
      idx <= '0;
      exp_l <= expected_tt;
      sweep_tt <= '0;
      sweep_match <= 1'b0;
    end else if (state == SWEEP) begin
      if (!last) idx <= idx + 1'b1;
      sweep_tt <= tt_next;
      if (last) sweep_match <= tt_next == exp_l;
    end
`ifdef TT_SWEEP_MISMATCH_CNT_EN
  // Per-row disagreement count against the golden table
  always_ff @(posedge clk or posedge rst)
    if (rst) mismatch_cnt <= '0;
    else if (start_acc) mismatch_cnt <= '0;
    else if (state == SWEEP && lut_bit != exp_l[idx]) mismatch_cnt <= mismatch_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_tt_sweep_eval.sv
// tb_tt_sweep_eval: directed bench with a cycle-level reference model for tt_sweep_eval
module tb_tt_sweep_eval;
  localparam int N = 4;
  localparam int TT = 16;
  logic clk = 0, rst = 1, cfg_we = 0, in_valid = 0, out_ready = 1, sweep_start = 0;
  logic [TT-1:0] cfg_tt = '0, expected_tt = '0;
  logic [N-1:0] in_vec = '0;
  logic in_ready, out_valid, out_bit, sweep_busy, sweep_done, sweep_match;
  logic [TT-1:0] sweep_tt;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
  logic [N:0] mismatch_cnt;
`endif
  int total = 0, bad = 0;
  bit chk_on = 0;

  tt_sweep_eval #(.N_IN(N)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .sweep_start(sweep_start), .expected_tt(expected_tt),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_match(sweep_match),
`ifdef TT_SWEEP_MISMATCH_CNT_EN
    .mismatch_cnt(mismatch_cnt),
`endif
    .sweep_tt(sweep_tt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [TT-1:0] low_mask(input int n);
    logic [31:0] t;
    t = (32'd1 << n) - 32'd1;
    return t[TT-1:0];
  endfunction

  // Reference model: k counts cycles since a sweep was accepted (0 = not sweeping,
  // 1..TT = evaluating rows, TT+1 = done cycle); snap is the table the sweep sees.
  logic [TT-1:0] m_tt = 16'h2FC7, snap = '0, m_exp = '0, m_stt = '0;
  logic m_ov = 0, m_ob = 0, m_match = 0;
  int k = 0, m_cnt = 0;
  wire m_rdy = !rst && k == 0 && !sweep_start && (!m_ov || out_ready);
  wire m_acc = k == 0 && sweep_start && !m_ov;
  wire m_busy = k >= 1 && k <= TT;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_tt <= 16'h2FC7; m_ov <= 0; m_ob <= 0; k <= 0;
      m_stt <= '0; m_match <= 0; m_cnt <= 0;
    end else begin
      if (in_valid && m_rdy) begin
        m_ov <= 1;
        m_ob <= m_tt[in_vec];
      end else if (out_ready) m_ov <= 0;
      if (cfg_we && !m_busy) m_tt <= cfg_tt;
      if (m_acc) begin
        k <= 1; snap <= cfg_we ? cfg_tt : m_tt; m_exp <= expected_tt;
        m_match <= 0; m_stt <= '0; m_cnt <= 0;
      end else if (k == TT + 1) k <= 0;
      else if (k != 0) begin
        k <= k + 1;
        m_stt <= snap & low_mask(k);
        if (k == TT) begin
          m_match <= snap == m_exp;
          m_cnt <= $countones(snap ^ m_exp);
        end
      end
    end

  // Every-cycle comparison against the model
  always @(negedge clk)
    if (chk_on) begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_ov);
      chk("out_bit", out_bit, m_ob);
      chk("sweep_busy", sweep_busy, m_busy);
      chk("sweep_done", sweep_done, k == TT + 1);
      chk("sweep_match", sweep_match, m_match);
      chk("sweep_tt", sweep_tt, m_stt);
`ifdef TT_SWEEP_MISMATCH_CNT_EN
      if (k == TT + 1) chk("mismatch_cnt", mismatch_cnt, m_cnt);
`endif
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [TT-1:0] e);
    sweep_start = 1;
    expected_tt = e;
    step();
    sweep_start = 0;
  endtask

  task automatic wait_done(input int n0);
    int n = n0;
    while (!sweep_done && n < 60) begin
      step();
      n++;
    end
    chk("done_latency", n, 17);
  endtask

  task automatic cfg(input logic [TT-1:0] v);
    cfg_we = 1;
    cfg_tt = v;
    step();
    cfg_we = 0;
  endtask

  initial begin
    logic [3:0] vecs [4] = '{4'd0, 4'd3, 4'd6, 4'd15};
    logic exps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    step();
    chk_on = 1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sweep_tt", sweep_tt, 0);
    rst = 0;
    step();
    // Default table streaming, back to back
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_vec = vecs[i];
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_bit", out_bit, exps[i]);
    end
    in_valid = 0;
    step();
    // Backpressure
    out_ready = 0;
    in_valid = 1;
    in_vec = 4'd1;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_bit", out_bit, 1);
      chk("bp_ready", in_ready, 0);
      step();
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    // Matching sweep
    start_sweep(16'h2FC7);
    wait_done(1);
    chk("sw1_match", sweep_match, 1);
    chk("sw1_tt", sweep_tt, 16'h2FC7);
`ifdef TT_SWEEP_MISMATCH_CNT_EN
    chk("sw1_cnt", mismatch_cnt, 0);
`endif
    step();
    // One-bit-different table
    cfg(16'h2FC6);
    start_sweep(16'h2FC7);
    wait_done(1);
    chk("sw2_match", sweep_match, 0);
    chk("sw2_tt", sweep_tt, 16'h2FC6);
`ifdef TT_SWEEP_MISMATCH_CNT_EN
    chk("sw2_cnt", mismatch_cnt, 1);
`endif
    step();
    chk("sw2_held", sweep_tt, 16'h2FC6);
    // cfg write during sweep is ignored
    cfg(16'h2FC7);
    start_sweep(16'h2FC7);
    repeat (4) step();
    cfg(16'h0000);
    wait_done(6);
    chk("sw3_tt", sweep_tt, 16'h2FC7);
    chk("sw3_match", sweep_match, 1);
    step();
    cfg(16'h0001);
    in_valid = 1;
    in_vec = 4'd0;
    step();
    chk("cfg_new_v0", out_bit, 1);
    in_vec = 4'd1;
    step();
    chk("cfg_new_v1", out_bit, 0);
    in_valid = 0;
    step();
    // Reset mid-sweep
    start_sweep(16'h2FC7);
    repeat (7) step();
    chk("pre_rst_busy", sweep_busy, 1);
    rst = 1;
    #1;
    chk("rst_busy", sweep_busy, 0);
    chk("rst_tt", sweep_tt, 0);
    chk("rst_ready", in_ready, 0);
    step();
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      chk("no_done", sweep_done, 0);
      step();
    end
    start_sweep(16'h2FC7);
    wait_done(1);
    chk("sw4_match", sweep_match, 1);
    chk("sw4_tt", sweep_tt, 16'h2FC7);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_sweep_eval.md
Name: tt_sweep_eval

Overview:
- Parametrised, registered truth-table evaluator for N-input single-output Boolean functions.
- Successor to the fixed 4-input gate netlists; the function is a loadable truth-table register, not hard-wired logic.
- Two uses: streamed per-vector evaluation with valid/ready handshakes, and an exhaustive sweep mode.
- Sweep mode walks all 2^N input rows, rebuilds the table and checks it against an expected table. It sits beside synthesized gate netlists for equivalence checking.

Parameters:
- N_IN, 4, number of function inputs (1..8).
- TT_W, 2**N_IN, truth-table width. Derived; do not override.
- TT_RST, 'h2FC7, truth-table register reset value. Zero-extended or truncated to TT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  load cfg_tt into the truth-table register.
- cfg_tt  in  TT_W  new truth table; bit i = output for input row i.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts an input vector.
- in_vec  in  N_IN  input vector; bit 0 = input _0.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  function value of the accepted vector.
- sweep_start  in  1  request an exhaustive sweep.
- expected_tt  in  TT_W  golden table; sampled at sweep start.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the sweep completes.
- sweep_match  out  1  rebuilt table equals expected; held until the next accepted sweep_start.
- sweep_tt  out  TT_W  table rebuilt by the sweep; held.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - Reset values: truth-table register = TT_RST; in_ready=0 while rst is high, then follows its equation; out_valid=0; out_bit=0.
  - Also at reset: sweep_busy=0, sweep_done=0, sweep_match=0, sweep_tt=0; FSM = IDLE.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start when out_valid=0. The cycle this happens is the start-accept cycle.
  - SWEEP -> DONE after row TT_W-1 is evaluated.
  - DONE -> IDLE unconditionally after one cycle.
- Stream evaluation:
  - in_ready = (state==IDLE) && !sweep_start && (!out_valid || out_ready).
  - A transfer happens when in_valid && in_ready. Next cycle out_valid=1 and out_bit=tt[in_vec]. Latency is 1 cycle.
  - out_valid/out_bit hold while out_ready=0. out_valid clears after out_valid && out_ready with no new transfer.
  - Back-to-back transfers give 1 result per cycle.
- Sweep:
  - On start-accept, latch expected_tt, clear the row counter and clear sweep_tt.
  - Each SWEEP cycle evaluates row idx through the same LUT path and writes sweep_tt[idx]. idx is an N_IN-bit counter; it ends on reaching TT_W-1 with no wrap.
  - sweep_busy=1 in SWEEP. In DONE: sweep_done=1 and sweep_match=(sweep_tt==latched expected).
  - sweep_done rises TT_W+1 cycles after start-accept (17 for N_IN=4).
- Truth-table writes:
  - cfg_we is honoured in IDLE and DONE; it is ignored in SWEEP so the sweep sees a stable table.
  - cfg_we coincident with an input transfer: the transfer uses the old table, and the new table applies from the next cycle.
- Boundary cases:
  - sweep_start while busy or while out_valid=1: ignored. The requester must hold it.
  - Stream inputs during SWEEP/DONE: in_ready=0.
  - rst mid-sweep aborts immediately to reset values; no sweep_done is produced.
  - N_IN=1: TT_W=2, so the sweep lasts 2 cycles.

Optional Feature:
- Macro TT_SWEEP_MISMATCH_CNT_EN.
- Defined:
  - Adds output port mismatch_cnt, width N_IN+1.
  - Cleared on start-accept; +1 for each row where the evaluated bit differs from the latched expected bit.
  - Final value valid with sweep_done and held until the next sweep.
  - sweep_match == (mismatch_cnt==0).
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tt_eval_pkg: FSM state enum (IDLE/SWEEP/DONE), function tt_width(n) returning 2**n, N_IN upper-bound constant (8).
- Sub-module tt_lut_mux: purely combinational TT_W:1 select of tt[sel]. It is instantiated once and shared by the stream and sweep paths through a select mux driven by state.

Test Plan:
- Default table after reset, stream in_vec 0, 3, 6, 15 with out_ready=1 -> out_bit 1, 0, 1, 0, each 1 cycle after its transfer. Table value 0x2FC7.
- Backpressure: out_ready=0 for 3 cycles after a transfer of vec 1 -> out_valid stays 1, out_bit stays 1, in_ready=0. Release -> in_ready=1 in the same cycle.
- Sweep, expected_tt=0x2FC7 -> sweep_busy for 16 cycles, sweep_done at cycle 17, sweep_match=1, sweep_tt=0x2FC7. With the macro, mismatch_cnt=0.
- cfg_tt=0x2FC6 written in IDLE, sweep with expected 0x2FC7 -> sweep_match=0, sweep_tt=0x2FC6. With the macro, mismatch_cnt=1.
- cfg_we=1 with cfg_tt=0x0000 at sweep cycle 5 -> ignored; sweep_tt=0x2FC7. A cfg write in IDLE afterwards takes effect.
- rst pulse at sweep cycle 8 -> all outputs at reset values, no sweep_done. A new sweep_start then completes normally after 17 cycles.
